axi_lite_cdc_slave_port: RTL and testbench

Source-domain front end of the AXI4-Lite clock-domain-crossing bridge, clocked by s_clk_i. It accepts AXI4-Lite write (AW+W) and read (AR) requests from the upstream master and packs them into single words that it pushes into a request async FIFO. It pops packed responses from a response async FIFO and returns them on the B or R channel. A bounded in-order outstanding counter provides flow control.

---
 rtl/axi_lite_cdc_slave_port.sv | 119 +++++++++++
 tb/tb_axi_lite_cdc_slave_port.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cdc_slave_port.sv
// Source-side front end of the AXI4-Lite CDC bridge: packs AW+W / AR requests into the
// request FIFO and replays packed responses from the response FIFO onto B / R.
module axi_lite_cdc_slave_port #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 4,
    localparam int STRB_WIDTH     = DATA_WIDTH / 8,
    localparam int REQ_WIDTH      = 1 + ADDR_WIDTH + 3 + DATA_WIDTH + STRB_WIDTH,
    localparam int RSP_WIDTH      = 3 + DATA_WIDTH
) (
    input  logic                  s_clk_i,
    input  logic                  s_rst_ni,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [2:0]            s_awprot,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0] s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic [2:0]            s_arprot,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  req_wr_en,
    output logic [REQ_WIDTH-1:0]  req_wr_data,
    input  logic                  req_full,
    output logic                  rsp_rd_en,
    input  logic [RSP_WIDTH-1:0]  rsp_rd_data,
    input  logic                  rsp_empty
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0]         count;
    logic                  prio_wr;
    logic                  fetch_pending;
    logic                  slot_valid;
    logic                  slot_is_write;
    logic [1:0]            slot_resp;
    logic [DATA_WIDTH-1:0] slot_data;

    logic wr_cand, rd_cand, can_push, grant_wr, grant_rd, push, slot_hs;

    // Request side: AW and W are only ever accepted together, so one grant covers both.
    always_comb begin
        wr_cand  = s_awvalid && s_wvalid;
        rd_cand  = s_arvalid;
        can_push = !req_full && (count < CW'(MAX_OUTSTANDING));
        grant_wr = can_push && wr_cand && (prio_wr || !rd_cand);
        grant_rd = can_push && rd_cand && (!prio_wr || !wr_cand);
        push     = grant_wr || grant_rd;
    end

    assign s_awready = grant_wr;
    assign s_wready  = grant_wr;
    assign s_arready = grant_rd;
    assign req_wr_en = push;
    assign req_wr_data = grant_wr
        ? {1'b1, s_awaddr, s_awprot, s_wdata, s_wstrb}
        : {1'b0, s_araddr, s_arprot, {DATA_WIDTH{1'b0}}, {STRB_WIDTH{1'b0}}};

    assign slot_hs   = slot_valid && (slot_is_write ? s_bready : s_rready);
    assign rsp_rd_en = !rsp_empty && !fetch_pending && (!slot_valid || slot_hs);

    assign s_bvalid = slot_valid && slot_is_write;
    assign s_rvalid = slot_valid && !slot_is_write;
    assign s_bresp  = slot_resp;
    assign s_rresp  = slot_resp;
    assign s_rdata  = slot_data;

    always_ff @(posedge s_clk_i or negedge s_rst_ni) begin
        if (!s_rst_ni) begin
            count   <= '0;
            prio_wr <= 1'b1;
        end else begin
            if (push && !slot_hs) begin
                count <= count + CW'(1);
            end else if (!push && slot_hs && (count != '0)) begin
                count <= count - CW'(1);
            end
            // The losing side (or the idle side) gets priority next time.
            if (push) begin
                prio_wr <= grant_rd;
            end
        end
    end

    always_ff @(posedge s_clk_i or negedge s_rst_ni) begin
        if (!s_rst_ni) begin
            fetch_pending <= 1'b0;
            slot_valid    <= 1'b0;
            slot_is_write <= 1'b0;
            slot_resp     <= 2'b00;
            slot_data     <= '0;
        end else begin
            fetch_pending <= rsp_rd_en;
            if (fetch_pending) begin
                slot_valid    <= 1'b1;
                slot_is_write <= rsp_rd_data[RSP_WIDTH-1];
                slot_resp     <= rsp_rd_data[DATA_WIDTH +: 2];
                // Write responses carry no data; keep s_rdata untouched by them.
                if (!rsp_rd_data[RSP_WIDTH-1]) begin
                    slot_data <= rsp_rd_data[DATA_WIDTH-1:0];
                end
            end else if (slot_hs) begin
                slot_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_cdc_slave_port.sv
// Self-checking bench: request/response scoreboards plus a table of single transactions
// and hand-written sequences for arbitration, outstanding limit, back-pressure and reset.
module tb_axi_lite_cdc_slave_port;

    localparam int REQW = 72;
    localparam int RSPW = 35;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic        req_wr_en, req_full, rsp_rd_en, rsp_empty;
    logic [REQW-1:0] req_wr_data;
    logic [RSPW-1:0] rsp_rd_data;

    always #5 clk = ~clk;

    axi_lite_cdc_slave_port #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
    ) dut (
        .s_clk_i(clk), .s_rst_ni(rst_n),
        .s_awvalid(awvalid), .s_awready(awready), .s_awaddr(awaddr), .s_awprot(awprot),
        .s_wvalid(wvalid), .s_wready(wready), .s_wdata(wdata), .s_wstrb(wstrb),
        .s_bvalid(bvalid), .s_bready(bready), .s_bresp(bresp),
        .s_arvalid(arvalid), .s_arready(arready), .s_araddr(araddr), .s_arprot(arprot),
        .s_rvalid(rvalid), .s_rready(rready), .s_rdata(rdata), .s_rresp(rresp),
        .req_wr_en(req_wr_en), .req_wr_data(req_wr_data), .req_full(req_full),
        .rsp_rd_en(rsp_rd_en), .rsp_rd_data(rsp_rd_data), .rsp_empty(rsp_empty)
    );

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [2:0]  prot;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs[6];

    int checks = 0;
    int failures = 0;
    int push_cnt = 0;
    int rsp_cnt = 0;

    logic [REQW-1:0] exp_req[$];
    logic [RSPW-1:0] exp_rsp[$];
    logic [RSPW-1:0] rsp_fifo[$];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [REQW-1:0] pack_req(input bit w, input logic [31:0] a,
                                                 input logic [2:0] p, input logic [31:0] d,
                                                 input logic [3:0] s);
        if (w) return {1'b1, a, p, d, s};
        return {1'b0, a, p, 32'h0, 4'h0};
    endfunction

    // Response FIFO model: registered empty flag, data one cycle after the pop.
    logic fire;
    initial begin
        rsp_rd_data = '0;
        rsp_empty = 1'b1;
        fire = 1'b0;
        forever begin
            @(negedge clk);
            fire = rsp_rd_en && rst_n;
            @(posedge clk);
            #1;
            if (fire && rst_n) begin
                if (rsp_fifo.size() > 0) begin
                    rsp_rd_data = rsp_fifo.pop_front();
                end else begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_pop_empty t=%0t", $time);
                end
            end
            rsp_empty = (rsp_fifo.size() == 0);
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [RSPW-1:0] g, e;
        if (rst_n) begin
            check("ready_pair", 128'(awready), 128'(wready));
            check("ready_excl", 128'(awready && arready), 128'(0));
            if (req_wr_en) begin
                push_cnt++;
                if (exp_req.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL req_unexpected got=%0h exp=none", req_wr_data);
                end else begin
                    check("req_word", 128'(req_wr_data), 128'(exp_req.pop_front()));
                end
            end
            if ((bvalid && bready) || (rvalid && rready)) begin
                rsp_cnt++;
                g = bvalid ? {1'b1, bresp, 32'h0} : {1'b0, rresp, rdata};
                if (exp_rsp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected got=%0h exp=none", g);
                end else begin
                    e = exp_rsp.pop_front();
                    if (e[RSPW-1]) e[31:0] = 32'h0;
                    check("rsp_word", 128'(g), 128'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_reset_outs(input string name);
        check(name, 128'({awready, wready, arready, bvalid, rvalid, req_wr_en, rsp_rd_en,
                          bresp, rresp, rdata}), 128'(0));
        check({name, "_count"}, 128'(dut.count), 128'(0));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; req_full = 1'b0;
        exp_req.delete(); exp_rsp.delete(); rsp_fifo.delete();
        rsp_empty = 1'b1;
        #1;
        check_reset_outs("reset_outs");
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drive_req(input bit w, input logic [31:0] a, input logic [2:0] p,
                             input logic [31:0] d, input logic [3:0] s);
        if (w) begin
            awvalid = 1'b1; wvalid = 1'b1; awaddr = a; awprot = p; wdata = d; wstrb = s;
        end else begin
            arvalid = 1'b1; araddr = a; arprot = p;
        end
        exp_req.push_back(pack_req(w, a, p, d, s));
    endtask

    task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] p,
                         input logic [31:0] d, input logic [3:0] s);
        bit ok;
        drive_req(w, a, p, d, s);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            #1;
            if (w ? awready : arready) begin
                ok = 1'b1;
                break;
            end
        end
        check("grant_seen", 128'(ok), 128'(1));
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    endtask

    task automatic feed_rsp(input bit w, input logic [1:0] r, input logic [31:0] d);
        rsp_fifo.push_back({w, r, d});
        exp_rsp.push_back({w, r, d});
    endtask

    task automatic wait_rsp(input int target);
        for (int k = 0; k < 100 && rsp_cnt < target; k++) tick();
        check("rsp_done", 128'(rsp_cnt), 128'(target));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int tgt;
        bit seen;
        vecs[0] = '{1'b1, 32'h0000_1000, 3'd0, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h0000_2004, 3'd0, 32'h0,         4'h0, 2'b10, 32'h1234_5678};
        vecs[2] = '{1'b1, 32'h0000_0FFC, 3'd7, 32'h0,         4'h0, 2'b01, 32'h0};
        vecs[3] = '{1'b0, 32'hFFFF_FFFC, 3'd5, 32'h0,         4'h0, 2'b11, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 32'h8000_0000, 3'd2, 32'hA5A5_5A5A, 4'h5, 2'b10, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0000, 3'd1, 32'h0,         4'h0, 2'b00, 32'h0};

        awaddr = '0; awprot = '0; wdata = '0; wstrb = '0; araddr = '0; arprot = '0;
        bready = 1'b1; rready = 1'b1;
        @(posedge clk);
        do_reset();

        // Table of single transactions, including the latency check.
        foreach (vecs[i]) begin
            issue(vecs[i].is_wr, vecs[i].addr, vecs[i].prot, vecs[i].data, vecs[i].strb);
            tgt = rsp_cnt + 1;
            feed_rsp(vecs[i].is_wr, vecs[i].resp,
                     vecs[i].is_wr ? 32'hCAFE_0000 + 32'(i) : vecs[i].rdata);
            seen = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (rsp_rd_en) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            check("rd_en_seen", 128'(seen), 128'(1));
            tick();
            check("lat_t1", 128'({bvalid, rvalid}), 128'(0));
            tick();
            check("lat_t2", 128'({bvalid, rvalid}), 128'({vecs[i].is_wr, !vecs[i].is_wr}));
            check("resp_field", 128'(vecs[i].is_wr ? bresp : rresp), 128'(vecs[i].resp));
            if (!vecs[i].is_wr) check("rdata_field", 128'(rdata), 128'(vecs[i].rdata));
            wait_rsp(tgt);
            check("count_idle", 128'(dut.count), 128'(0));
        end

        // Simultaneous write and read from reset: W,R,W,R.
        do_reset();
        tgt = push_cnt + 4;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        awaddr = 32'h0000_0100; awprot = 3'd1; wdata = 32'h1111_2222; wstrb = 4'h3;
        araddr = 32'h0000_0200; arprot = 3'd4;
        for (int k = 0; k < 2; k++) begin
            exp_req.push_back(pack_req(1'b1, 32'h0000_0100, 3'd1, 32'h1111_2222, 4'h3));
            exp_req.push_back(pack_req(1'b0, 32'h0000_0200, 3'd4, 32'h0, 4'h0));
        end
        repeat (4) tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("simul_pushes", 128'(push_cnt), 128'(tgt));
        tgt = rsp_cnt + 4;
        feed_rsp(1'b1, 2'b00, 32'h0);
        feed_rsp(1'b0, 2'b00, 32'h0000_00A1);
        feed_rsp(1'b1, 2'b01, 32'h0);
        feed_rsp(1'b0, 2'b11, 32'h0000_00A2);
        wait_rsp(tgt);

        // Outstanding limit: four reads fill the window, the fifth waits.
        for (int k = 0; k < 4; k++) issue(1'b0, 32'h3000 + 32'(4 * k), 3'd0, 32'h0, 4'h0);
        check("count_full", 128'(dut.count), 128'(4));
        tgt = push_cnt + 1;
        drive_req(1'b0, 32'h0000_3010, 3'd3, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            check("limit_block", 128'({arready, req_wr_en}), 128'(0));
            tick();
        end
        feed_rsp(1'b0, 2'b00, 32'h0000_0B00);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rvalid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("limit_rvalid", 128'(seen), 128'(1));
        check("limit_hs_cycle", 128'(arready), 128'(0));
        tick();
        check("limit_resume", 128'(arready), 128'(1));
        tick();
        arvalid = 1'b0;
        check("limit_push", 128'(push_cnt), 128'(tgt));
        tgt = rsp_cnt + 4;
        for (int k = 1; k < 5; k++) feed_rsp(1'b0, 2'b00, 32'h0000_0B00 + 32'(k));
        wait_rsp(tgt);

        // Back-pressure from a full request FIFO.
        req_full = 1'b1;
        tgt = push_cnt + 1;
        drive_req(1'b1, 32'h0000_4000, 3'd6, 32'h5555_AAAA, 4'h9);
        for (int k = 0; k < 3; k++) begin
            #1;
            check("full_block", 128'({awready, wready, arready, req_wr_en}), 128'(0));
            tick();
        end
        req_full = 1'b0;
        #1;
        check("full_release", 128'({awready, wready, req_wr_en}), 128'(3'b111));
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check("full_push", 128'(push_cnt), 128'(tgt));
        tgt = rsp_cnt + 1;
        feed_rsp(1'b1, 2'b10, 32'h0);
        wait_rsp(tgt);

        // Reset with a valid slot and a fetch about to be issued.
        rready = 1'b0;
        issue(1'b0, 32'h0000_5000, 3'd0, 32'h0, 4'h0);
        issue(1'b0, 32'h0000_5004, 3'd0, 32'h0, 4'h0);
        feed_rsp(1'b0, 2'b01, 32'h0000_0C01);
        feed_rsp(1'b0, 2'b00, 32'h0000_0C02);
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (rvalid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("rst_slot_valid", 128'(seen), 128'(1));
        tick();
        check("rst_slot_hold", 128'({rvalid, rsp_rd_en, rdata}), 128'({2'b10, 32'h0000_0C01}));
        rready = 1'b1;
        #1;
        check("rst_fetch_ready", 128'(rsp_rd_en), 128'(1));
        #1;
        do_reset();
        check_reset_outs("post_reset_outs");
        tgt = rsp_cnt + 1;
        issue(1'b0, 32'h0000_6000, 3'd2, 32'h0, 4'h0);
        feed_rsp(1'b0, 2'b00, 32'h0000_0D0D);
        wait_rsp(tgt);
        tick();
        check("final_count", 128'(dut.count), 128'(0));
        check("req_left", 128'(exp_req.size()), 128'(0));
        check("rsp_left", 128'(exp_rsp.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
